// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state enum, range limits and output widths for the stopwatch
// and its seven-segment encoder.
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, FULL} state_t;
  localparam int MINS_W = 7;
  localparam int SECS_W = 6;
  localparam int DECS_W = 7;
  localparam logic [DECS_W-1:0] DECS_MAX = 7'd99;
  localparam logic [SECS_W-1:0] SECS_MAX = 6'd59;
  localparam logic [MINS_W-1:0] MINS_MAX = 7'd99;
endpackage

// File: rtl/stopwatch_prescaler.sv
// stopwatch_prescaler: divides clk by DIV while enabled, holding its count when disabled.
// Ports: clk, rst_n (async active-low), en (count enable), clr (sync zero), tick (one clk at DIV-1).
module stopwatch_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  logic [W-1:0] cnt;
  assign tick = en && (cnt == LAST);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/stopwatch_unit.sv
// stopwatch_unit: 100 Hz stopwatch core with start/stop, clear and optional lap hold.
// Ports: clk, rst_n (async active-low), start_stop/clear/lap (debounced levels, rising edge acts),
//        stopwatch_unit_mins/secs/decs (binary counts), running (RUN), overflow (FULL).
// Option: define STOPWATCH_LAP_EN to enable the lap snapshot on the outputs.
module stopwatch_unit
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_stop,
  input  logic              clear,
  input  logic              lap,
  output logic [MINS_W-1:0] stopwatch_unit_mins,
  output logic [SECS_W-1:0] stopwatch_unit_secs,
  output logic [DECS_W-1:0] stopwatch_unit_decs,
  output logic              running,
  output logic              overflow
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  state_t state, state_d;
  logic ss_q, clr_q, ss_e, clr_e, tick, at_max;
  logic [MINS_W-1:0] mins_r;
  logic [SECS_W-1:0] secs_r;
  logic [DECS_W-1:0] decs_r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {ss_q, clr_q} <= '0;
    else {ss_q, clr_q} <= {start_stop, clear};
  assign ss_e   = start_stop & ~ss_q;
  assign clr_e  = clear & ~clr_q;
  assign at_max = (decs_r == DECS_MAX) && (secs_r == SECS_MAX) && (mins_r == MINS_MAX);
  stopwatch_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == RUN),
    .clr  (clr_e),
    .tick (tick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  // Saturation wins over a start_stop edge arriving on the final tick.
  always_comb begin
    state_d  = state;
    running  = (state == RUN);
    overflow = (state == FULL);
    if (clr_e) state_d = IDLE;
    else if (state == RUN && tick && at_max) state_d = FULL;
    else if (ss_e && state != FULL) state_d = (state == RUN) ? PAUSE : RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      decs_r <= '0;
      secs_r <= '0;
      mins_r <= '0;
    end else if (clr_e) begin
      decs_r <= '0;
      secs_r <= '0;
      mins_r <= '0;
    end else if (tick && !at_max) begin
      if (decs_r != DECS_MAX) decs_r <= decs_r + 1'b1;
      else begin
        decs_r <= '0;
        if (secs_r != SECS_MAX) secs_r <= secs_r + 1'b1;
        else begin
          secs_r <= '0;
          mins_r <= mins_r + 1'b1;
        end
      end
    end
`ifdef STOPWATCH_LAP_EN
  logic lap_q, lap_e, lap_hold;
  logic [MINS_W-1:0] snap_m;
  logic [SECS_W-1:0] snap_s;
  logic [DECS_W-1:0] snap_d;
  assign lap_e = lap & ~lap_q;
  // The snapshot captures the counters as they stand before the lap edge updates them.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lap_q    <= 1'b0;
      lap_hold <= 1'b0;
      snap_m   <= '0;
      snap_s   <= '0;
      snap_d   <= '0;
    end else begin
      lap_q <= lap;
      if (clr_e || state_d == FULL) lap_hold <= 1'b0;
      else if (state == RUN && lap_e) begin
        lap_hold <= ~lap_hold;
        if (!lap_hold) {snap_m, snap_s, snap_d} <= {mins_r, secs_r, decs_r};
      end
    end
  assign stopwatch_unit_mins = lap_hold ? snap_m : mins_r;
  assign stopwatch_unit_secs = lap_hold ? snap_s : secs_r;
  assign stopwatch_unit_decs = lap_hold ? snap_d : decs_r;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign stopwatch_unit_mins = mins_r;
  assign stopwatch_unit_secs = secs_r;
  assign stopwatch_unit_decs = decs_r;
`endif
endmodule

// File: tb/tb_stopwatch_unit.sv
// tb_stopwatch_unit: self-checking bench for stopwatch_unit with DIV = 10.
module tb_stopwatch_unit;
  localparam int DIV  = 10;
  localparam int MAXT = 99 * 6000 + 59 * 100 + 99;

  typedef struct {
    bit ss;
    bit cl;
    int n;
    int d;
    int r;
    int o;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [6:0] mins, decs;
  logic [5:0] secs;
  logic running, overflow;
  logic [6:0] pl_m, pl_d;
  logic [5:0] pl_s;

  stopwatch_unit #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start_stop         (start_stop),
    .clear              (clear),
    .lap                (lap),
    .stopwatch_unit_mins(mins),
    .stopwatch_unit_secs(secs),
    .stopwatch_unit_decs(decs),
    .running            (running),
    .overflow           (overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // Reference: elapsed hundredths as one integer, phase within the current tick, mode flags.
  int m_t, m_ph, m_snap;
  bit m_run, m_pau, m_full, m_hold, p_ss, p_clr, p_lap;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_t = 0; m_ph = 0; m_run = 0; m_pau = 0; m_full = 0; m_hold = 0;
  endfunction

  function automatic void model_reset();
    model_clear();
    m_snap = 0; p_ss = 0; p_clr = 0; p_lap = 0;
  endfunction

  function automatic void model_step();
    bit se = start_stop & !p_ss;
    bit ce = clear & !p_clr;
    bit le = lap & !p_lap;
    bit r0 = m_run;
    bit i0 = !(m_run | m_pau | m_full);
    int t0 = m_t;
    bit tk;
    p_ss = start_stop; p_clr = clear; p_lap = lap;
    if (ce) begin
      model_clear();
      return;
    end
    tk = r0 && (m_ph == DIV - 1);
    if (r0) m_ph = (m_ph + 1) % DIV;
    if (tk && t0 == MAXT) begin
      m_full = 1; m_run = 0; m_hold = 0;
      return;
    end
    if (tk) m_t = t0 + 1;
    if (se && r0) begin
      m_run = 0; m_pau = 1;
    end else if (se && (i0 || m_pau)) begin
      m_run = 1; m_pau = 0;
    end
`ifdef STOPWATCH_LAP_EN
    if (le && r0) begin
      m_hold = !m_hold;
      if (m_hold) m_snap = t0;
    end
`else
    if (le) m_snap = m_snap;
`endif
  endfunction

  task automatic check_model(input string nm);
    int v = m_hold ? m_snap : m_t;
    chk({nm, ".mins"}, int'(mins), v / 6000);
    chk({nm, ".secs"}, int'(secs), (v / 100) % 60);
    chk({nm, ".decs"}, int'(decs), v % 100);
    chk({nm, ".running"}, int'(running), int'(m_run));
    chk({nm, ".overflow"}, int'(overflow), int'(m_full));
  endtask

  task automatic check_disp(input string nm, input int m, input int s, input int d, input int r, input int o);
    chk({nm, ".mins"}, int'(mins), m);
    chk({nm, ".secs"}, int'(secs), s);
    chk({nm, ".decs"}, int'(decs), d);
    chk({nm, ".running"}, int'(running), r);
    chk({nm, ".overflow"}, int'(overflow), o);
  endtask

  task automatic step(input bit cm);
    @(posedge clk);
    model_step();
    #1;
    if (cm) check_model("model");
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1; step(1);
    start_stop = 1'b0; step(1);
  endtask

  // Loads the counters directly while paused, so long runs need not be clocked through.
  task automatic preload(input int m, input int s, input int d);
    pl_m = 7'(m); pl_s = 6'(s); pl_d = 7'(d);
    force dut.mins_r = pl_m;
    force dut.secs_r = pl_s;
    force dut.decs_r = pl_d;
    step(0);
    release dut.mins_r;
    release dut.secs_r;
    release dut.decs_r;
    m_t = m * 6000 + s * 100 + d;
    check_model("preload");
  endtask

  task automatic run_until(input string nm, input int target, input int budget);
    int k = 0;
    while (m_t != target && k < budget) begin
      step(1);
      k++;
    end
    chk({nm, ".reached"}, int'(m_t == target), 1);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{ss: 0, cl: 0, n: 2, d: 0, r: 0, o: 0};
    tbl[1] = '{ss: 1, cl: 0, n: 1, d: 0, r: 1, o: 0};
    tbl[2] = '{ss: 0, cl: 0, n: 9, d: 0, r: 1, o: 0};
    tbl[3] = '{ss: 0, cl: 0, n: 1, d: 1, r: 1, o: 0};
    tbl[4] = '{ss: 0, cl: 0, n: 9, d: 1, r: 1, o: 0};
    tbl[5] = '{ss: 0, cl: 0, n: 1, d: 2, r: 1, o: 0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_disp("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      start_stop = tbl[i].ss;
      clear = tbl[i].cl;
      for (int j = 0; j < tbl[i].n; j++) begin
        step(1);
        chk("tbl.decs", int'(decs), tbl[i].d);
        chk("tbl.running", int'(running), tbl[i].r);
        chk("tbl.overflow", int'(overflow), tbl[i].o);
      end
    end
    start_stop = 1'b0;
    repeat (980) step(1);
    check_disp("one_second", 0, 1, 0, 1, 0);

    repeat (3) step(1);
    start_stop = 1'b1; step(1);
    start_stop = 1'b0;
    repeat (50) step(1);
    check_disp("paused", 0, 1, 0, 0, 0);
    start_stop = 1'b1; step(1);
    start_stop = 1'b0;
    repeat (5) step(1);
    check_disp("resume5", 0, 1, 0, 1, 0);
    step(1);
    check_disp("resume6", 0, 1, 1, 1, 0);

    pulse_ss();
    preload(0, 59, 90);
    pulse_ss();
    run_until("to_59_99", 5999, 200);
    check_disp("at_59_99", 0, 59, 99, 1, 0);
    run_until("to_1_00", 6000, 20);
    check_disp("cascade", 1, 0, 0, 1, 0);

    pulse_ss();
    preload(99, 59, 98);
    pulse_ss();
    repeat (230) step(1);
    check_disp("saturate", 99, 59, 99, 0, 1);
    pulse_ss();
    repeat (20) step(1);
    check_disp("full_ignores_ss", 99, 59, 99, 0, 1);
    clear = 1'b1; step(1);
    clear = 1'b0;
    check_disp("clear_full", 0, 0, 0, 0, 0);

    pulse_ss();
    repeat (37) step(1);
    start_stop = 1'b1; clear = 1'b1; step(1);
    start_stop = 1'b0; clear = 1'b0;
    check_disp("priority", 0, 0, 0, 0, 0);
    repeat (30) step(1);
    check_disp("stay_idle", 0, 0, 0, 0, 0);

    start_stop = 1'b1; step(1);
    start_stop = 1'b0;
    repeat (500) step(1);
    check_disp("pre_lap", 0, 0, 50, 1, 0);
    lap = 1'b1; step(1);
    lap = 1'b0;
    check_disp("lap_set", 0, 0, 50, 1, 0);
    repeat (299) step(1);
`ifdef STOPWATCH_LAP_EN
    check_disp("lap_held", 0, 0, 50, 1, 0);
`else
    check_disp("lap_held", 0, 0, 80, 1, 0);
`endif
    lap = 1'b1; step(1);
    lap = 1'b0;
    check_disp("lap_release", 0, 0, 80, 1, 0);

    repeat (23) step(1);
    #2 rst_n = 1'b0;
    #1 check_disp("async_reset", 0, 0, 0, 0, 0);
    model_reset();
    #2 rst_n = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      start_stop = ($urandom_range(0, 5) == 0);
      clear = ($urandom_range(0, 99) == 0);
      lap = ($urandom_range(0, 9) == 0);
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stopwatch_unit.md
# stopwatch_unit

Timing core of the stopwatch: divides the system clock to a 100 Hz tick and maintains binary minutes/seconds/hundredths counters under start/stop, clear and lap control. Sits directly upstream of the seven-segment encoder, which consumes `stopwatch_unit_mins`, `stopwatch_unit_secs` and `stopwatch_unit_decs` unchanged. Inputs come from already-debounced, synchronised buttons.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency.
- `TICK_HZ`, default 100: count rate. `DIV = CLK_HZ/TICK_HZ`, which must be an integer ≥ 2.
- `clk`, input, 1: single system clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start_stop`, input, 1: level from the debounced button; each rising edge toggles run/pause.
- `clear`, input, 1: level; each rising edge returns the unit to zero/IDLE.
- `lap`, input, 1: level; each rising edge toggles the lap hold (see Configuration).
- `stopwatch_unit_mins`, output, 7: minutes, 0–99.
- `stopwatch_unit_secs`, output, 6: seconds, 0–59.
- `stopwatch_unit_decs`, output, 7: hundredths, 0–99.
- `running`, output, 1: high in RUN.
- `overflow`, output, 1: high in FULL.

## Operation
- **Edge detect:** each control input is registered once. An edge is `in & ~in_q`, evaluated at the same clock edge that acts on it.
- **FSM states:** IDLE, RUN, PAUSE, FULL.
- **IDLE:** a `start_stop` edge moves to RUN.
- **RUN:** a `start_stop` edge moves to PAUSE. A tick at 99:59.99 moves to FULL.
- **PAUSE:** a `start_stop` edge moves to RUN.
- **FULL:** `start_stop` is ignored.
- **Clear:** a `clear` edge in any state moves to IDLE.
- **Clear priority:** `clear` has priority over a simultaneous `start_stop` or `lap` edge.
- **Clear effect:** zeroes the prescaler and all counters, and releases any lap hold.
- **Prescaler:**
  - Counts 0..DIV-1 only in RUN.
  - Tick is asserted when the prescaler equals DIV-1 in RUN; the prescaler then wraps to 0.
  - In PAUSE the prescaler holds its value, so pause/resume loses no sub-tick time.
- **Counter cascade on tick:**
  - decs increments 0→99, then wraps to 0 and carries.
  - secs increments 0→59, then wraps to 0 and carries.
  - mins increments 0→99.
  - At 99:59.99 the counters hold and the state goes to FULL; no wrap to zero.
- **Width rule:** all comparisons use full port widths. Counter values above their range limits are unreachable.

## Timing
- **Reset:** all outputs are 0 and the state is IDLE. `in_q` registers reset to 0, so an input that is already high when reset releases produces an edge on the first clock.
- **Run latency:** the `start_stop` edge is seen at clock N. The state is RUN after N. The first tick is at clock N+DIV, and decs reads 1 after it.
- **Counter latency:** counters update on the same clock as the tick; outputs are registered.
- **`running` / `overflow`:** decoded from registered state; they change on the same edge as the state.
- **Mid-operation reset:** `rst_n` low at any time clears everything immediately (asynchronous). No partial count survives.
- **Clear while running:** the unit stays in IDLE; a new `start_stop` edge is required to run again.

## Configuration
- **Macro:** `STOPWATCH_LAP_EN`.
- **Defined, RUN:** a `lap` edge toggles `lap_hold`.
- **Defined, hold set:** the output ports show a snapshot latched at the set edge while the internal counters keep counting. The release edge returns the outputs to live values on the next clock.
- **Defined, other states:**
  - `lap` edges outside RUN are ignored.
  - Entering PAUSE keeps the hold.
  - FULL and `clear` release it.
- **Not defined:**
  - `lap` is present but unused; no snapshot registers exist.
  - Outputs always show live counters.

## Structure
- **Shared package `stopwatch_pkg`:**
  - The state enum (IDLE/RUN/PAUSE/FULL).
  - Limit constants: DECS_MAX=99, SECS_MAX=59, MINS_MAX=99.
  - The width constants 7/6/7 shared with the seven-segment encoder.
- **Sub-module `stopwatch_prescaler`:** inputs `clk`, `rst_n`, `en`, `clr`; output `tick`; parameter DIV.
- **Top level:** the FSM, edge detectors, counter cascade and lap snapshot stay in the top.

## Test plan
Bench uses `CLK_HZ`=1000, `TICK_HZ`=100, so DIV=10.

- **Run/pause/resume:**
  - Reset, then a `start_stop` pulse, then 1000 clocks: reads 00:01.00 and `running`=1.
  - Pulse `start_stop` at prescaler=4, wait 50 clocks: counters unchanged.
  - Resume: the next increment occurs after 6 clocks.
- **Cascade:** run to 00:59.99, then one tick: reads 01:00.00.
- **Saturation:** run to 99:59.99, then 20 more ticks: reads 99:59.99, `overflow`=1, `running`=0. A `start_stop` pulse is ignored.
- **Priority:** `clear` and `start_stop` rise on the same clock while in RUN: IDLE, all zero, `running`=0.
- **Lap (`STOPWATCH_LAP_EN`):**
  - `lap` at 00:00.50, then 300 clocks: outputs read 00:00.50.
  - `lap` again: outputs read 00:00.80 on the next clock.
  - Without the macro, outputs read 00:00.80 throughout.
- **Async reset:** assert `rst_n` low mid-count between clock edges: outputs are 0 before the next edge.
